// File: rtl/tt_lq_return_buf.sv
// rtl/tt_lq_return_buf.sv - in-order load-return buffer with out-of-order response fill
package tt_briscv_pkg;
  localparam int LQ_DEPTH = 8;

  typedef struct packed {
    logic       load;
    logic       vl_is_zero;
    logic [4:0] rd;
    logic [2:0] size;
  } lq_info_s;
endpackage

module tt_lq_return_buf #(
  parameter int LQ_DEPTH      = tt_briscv_pkg::LQ_DEPTH,
  parameter int LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH),
  parameter int DATA_W        = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_alloc_vld,
  output logic                           o_alloc_rdy,
  input  tt_briscv_pkg::lq_info_s        i_alloc_info,
  output logic [LQ_DEPTH_LOG2-1:0]       o_alloc_lqid,
  input  logic                           i_resp_vld,
  input  logic [LQ_DEPTH_LOG2-1:0]       i_resp_lqid,
  input  logic [DATA_W-1:0]              i_resp_data,
  output logic                           o_ret_vld,
  input  logic                           i_ret_rdy,
  output tt_briscv_pkg::lq_info_s        o_ret_info,
  output logic [DATA_W-1:0]              o_ret_data,
  output logic                           o_resp_err,
  output logic [LQ_DEPTH_LOG2:0]         o_count,
  output logic                           o_empty,
  output logic                           o_full
);
  localparam int PW = LQ_DEPTH_LOG2 + 1;

  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [LQ_DEPTH-1:0]      r_valid;
  logic [LQ_DEPTH-1:0]      r_done;
  tt_briscv_pkg::lq_info_s  r_info [LQ_DEPTH];
  logic [DATA_W-1:0]        r_data [LQ_DEPTH];
  logic                     r_resp_err;

  logic [LQ_DEPTH_LOG2-1:0] w_head_idx;
  logic [LQ_DEPTH_LOG2-1:0] w_tail_idx;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_alloc_fire;
  logic                     w_alloc_done;
  logic                     w_resp_legal;
  logic                     w_ret_vld;
  logic                     w_ret_fire;

  assign w_head_idx   = r_head[LQ_DEPTH_LOG2-1:0];
  assign w_tail_idx   = r_tail[LQ_DEPTH_LOG2-1:0];
  assign w_empty      = (r_head == r_tail);
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[PW-1] != r_tail[PW-1]);
  assign w_alloc_fire = i_alloc_vld && !w_full;
  // Non-loads and zero-length vector loads never see a memory response.
  assign w_alloc_done = !i_alloc_info.load || i_alloc_info.vl_is_zero;
  assign w_resp_legal = i_resp_vld && r_valid[i_resp_lqid] && !r_done[i_resp_lqid]
                        && r_info[i_resp_lqid].load;
  assign w_ret_vld    = r_valid[w_head_idx] && r_done[w_head_idx];
  assign w_ret_fire   = w_ret_vld && i_ret_rdy;

  assign o_alloc_rdy  = !w_full;
  assign o_alloc_lqid = w_tail_idx;
  assign o_ret_vld    = w_ret_vld;
  assign o_ret_info   = r_info[w_head_idx];
  assign o_ret_data   = r_data[w_head_idx];
  assign o_resp_err   = r_resp_err;
  assign o_count      = r_tail - r_head;
  assign o_empty      = w_empty;
  assign o_full       = w_full;

  // Alloc (tail), response (valid & !done) and retire (head, done) always touch distinct entries.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_resp_err <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_info[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_resp_err <= i_resp_vld && !w_resp_legal;
      if (w_alloc_fire) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= w_alloc_done;
        r_info[w_tail_idx]  <= i_alloc_info;
        if (w_alloc_done) begin
          r_data[w_tail_idx] <= '0;
        end
        r_tail <= r_tail + PW'(1);
      end
      if (w_resp_legal) begin
        r_done[i_resp_lqid] <= 1'b1;
        r_data[i_resp_lqid] <= i_resp_data;
      end
      if (w_ret_fire) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tt_lq_return_buf.sv
// tb/tb_tt_lq_return_buf.sv - scoreboard bench for tt_lq_return_buf
module tb_tt_lq_return_buf;
  import tt_briscv_pkg::*;

  typedef struct {
    lq_info_s    info;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_alloc_vld;
  lq_info_s    i_alloc_info;
  logic        o_alloc_rdy;
  logic [2:0]  o_alloc_lqid;
  logic        i_resp_vld;
  logic [2:0]  i_resp_lqid;
  logic [31:0] i_resp_data;
  logic        o_ret_vld;
  logic        i_ret_rdy;
  lq_info_s    o_ret_info;
  logic [31:0] o_ret_data;
  logic        o_resp_err;
  logic [3:0]  o_count;
  logic        o_empty;
  logic        o_full;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_err    = 0;
  logic [3:0]  exp_tail = 4'd0;
  logic [2:0]  ids [32];

  tt_lq_return_buf dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_alloc_vld  (i_alloc_vld),
    .o_alloc_rdy  (o_alloc_rdy),
    .i_alloc_info (i_alloc_info),
    .o_alloc_lqid (o_alloc_lqid),
    .i_resp_vld   (i_resp_vld),
    .i_resp_lqid  (i_resp_lqid),
    .i_resp_data  (i_resp_data),
    .o_ret_vld    (o_ret_vld),
    .i_ret_rdy    (i_ret_rdy),
    .o_ret_info   (o_ret_info),
    .o_ret_data   (o_ret_data),
    .o_resp_err   (o_resp_err),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_full       (o_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic lq_info_s mk(input logic ld, input logic vz, input logic [4:0] rd);
    lq_info_s r;
    r.load = ld;
    r.vl_is_zero = vz;
    r.rd = rd;
    r.size = 3'd2;
    return r;
  endfunction

  function automatic logic [31:0] dk(input int k);
    return 32'hD000 + 32'(k);
  endfunction

  // One clock of stimulus; an accepted alloc pushes its expected retire record.
  task automatic step(input logic av, input lq_info_s ai, input logic rv, input logic [2:0] rid,
                      input logic [31:0] rdat, input logic rr, input logic acc,
                      input logic [31:0] exp_data);
    exp_t e;
    i_alloc_vld  = av;
    i_alloc_info = ai;
    i_resp_vld   = rv;
    i_resp_lqid  = rid;
    i_resp_data  = rdat;
    i_ret_rdy    = rr;
    if (av) begin
      chk("alloc_rdy", 64'(o_alloc_rdy), 64'(acc));
      if (acc) begin
        chk("alloc_lqid", 64'(o_alloc_lqid), 64'(exp_tail[2:0]));
        e.info = ai;
        e.data = exp_data;
        sb.push_back(e);
        exp_tail = exp_tail + 4'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, 1'b0, 3'd0, 32'd0, rr, 1'b0, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ret_vld"},   64'(o_ret_vld),    64'd0);
    chk({tag, "_resp_err"},  64'(o_resp_err),   64'd0);
    chk({tag, "_count"},     64'(o_count),      64'd0);
    chk({tag, "_empty"},     64'(o_empty),      64'd1);
    chk({tag, "_full"},      64'(o_full),       64'd0);
    chk({tag, "_alloc_rdy"}, 64'(o_alloc_rdy),  64'd1);
    chk({tag, "_lqid"},      64'(o_alloc_lqid), 64'd0);
    chk({tag, "_ret_info"},  64'(o_ret_info),   64'd0);
    chk({tag, "_ret_data"},  64'(o_ret_data),   64'd0);
  endtask

  // Monitor: every retire handshake is matched against the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && o_ret_vld && i_ret_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL ret_unexpected: got retire data %0h expected no retire", o_ret_data);
      end else begin
        mon_e = sb.pop_front();
        chk("ret_info", 64'(o_ret_info), 64'(mon_e.info));
        chk("ret_data", 64'(o_ret_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_alloc_vld = 1'b0; i_alloc_info = '0; i_resp_vld = 1'b0;
    i_resp_lqid = '0; i_resp_data = '0; i_ret_rdy = 1'b0;
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);

    // Fill / drain
    for (int i = 0; i < 8; i++)
      step(1'b1, mk(1'b1, 1'b0, 5'(i)), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h100 + 32'(i));
    chk("fill_full", 64'(o_full), 64'd1);
    chk("fill_alloc_rdy", 64'(o_alloc_rdy), 64'd0);
    chk("fill_count", 64'(o_count), 64'd8);
    step(1'b1, mk(1'b1, 1'b0, 5'd9), 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("full_reject_count", 64'(o_count), 64'd8);
    for (int i = 0; i < 8; i++)
      step(1'b0, '0, 1'b1, 3'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 32'd0);
    idle(1'b1);
    chk("drain_empty", 64'(o_empty), 64'd1);
    chk("drain_count", 64'(o_count), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // Out-of-order completion
    step(1'b1, mk(1'b1, 1'b0, 5'd1), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'hA);
    step(1'b1, mk(1'b1, 1'b0, 5'd2), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'hB);
    step(1'b1, mk(1'b1, 1'b0, 5'd3), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'hC);
    step(1'b0, '0, 1'b1, 3'd2, 32'hC, 1'b1, 1'b0, 32'd0);
    chk("ooo_wait_c", 64'(o_ret_vld), 64'd0);
    step(1'b0, '0, 1'b1, 3'd1, 32'hB, 1'b1, 1'b0, 32'd0);
    chk("ooo_wait_b", 64'(o_ret_vld), 64'd0);
    step(1'b0, '0, 1'b1, 3'd0, 32'hA, 1'b1, 1'b0, 32'd0);
    chk("ooo_head_vld", 64'(o_ret_vld), 64'd1);
    chk("ooo_head_data", 64'(o_ret_data), 64'hA);
    idle(1'b1);
    chk("ooo_second", 64'(o_ret_data), 64'hB);
    idle(1'b1);
    chk("ooo_third", 64'(o_ret_data), 64'hC);
    idle(1'b1);
    chk("ooo_empty", 64'(o_empty), 64'd1);

    // Non-load and vl=0 bypass
    step(1'b1, mk(1'b0, 1'b0, 5'd4), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    chk("nonload_vld", 64'(o_ret_vld), 64'd1);
    chk("nonload_data", 64'(o_ret_data), 64'd0);
    step(1'b1, mk(1'b1, 1'b1, 5'd5), 1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    chk("vl0_vld", 64'(o_ret_vld), 64'd1);
    chk("vl0_count", 64'(o_count), 64'd1);
    idle(1'b1);
    chk("bypass_empty", 64'(o_empty), 64'd1);

    // Illegal responses
    step(1'b0, '0, 1'b1, 3'd5, 32'h99, 1'b0, 1'b0, 32'd0);
    chk("err_free", 64'(o_resp_err), 64'd1);
    chk("err_free_count", 64'(o_count), 64'd0);
    idle(1'b0);
    chk("err_pulse_clear", 64'(o_resp_err), 64'd0);
    step(1'b1, mk(1'b1, 1'b0, 5'd6), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h55);
    step(1'b0, '0, 1'b1, 3'd5, 32'h55, 1'b0, 1'b0, 32'd0);
    chk("legal_no_err", 64'(o_resp_err), 64'd0);
    step(1'b0, '0, 1'b1, 3'd5, 32'h99, 1'b0, 1'b0, 32'd0);
    chk("err_dup", 64'(o_resp_err), 64'd1);
    chk("dup_data_kept", 64'(o_ret_data), 64'h55);
    step(1'b1, mk(1'b0, 1'b0, 5'd7), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    step(1'b0, '0, 1'b1, 3'd6, 32'h77, 1'b0, 1'b0, 32'd0);
    chk("err_nonload", 64'(o_resp_err), 64'd1);
    step(1'b1, mk(1'b1, 1'b0, 5'd8), 1'b1, 3'd7, 32'h11, 1'b0, 1'b1, 32'h22);
    chk("err_same_cycle_alloc", 64'(o_resp_err), 64'd1);
    step(1'b0, '0, 1'b1, 3'd7, 32'h22, 1'b0, 1'b0, 32'd0);
    chk("late_resp_ok", 64'(o_resp_err), 64'd0);
    chk("illegal_count", 64'(o_count), 64'd3);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("illegal_empty", 64'(o_empty), 64'd1);

    // Wrap with three outstanding: alloc, response and retire in one cycle
    ids[0] = exp_tail[2:0];
    step(1'b1, mk(1'b1, 1'b0, 5'd0), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, dk(0));
    ids[1] = exp_tail[2:0];
    step(1'b1, mk(1'b1, 1'b0, 5'd1), 1'b1, ids[0], dk(0), 1'b0, 1'b1, dk(1));
    ids[2] = exp_tail[2:0];
    step(1'b1, mk(1'b1, 1'b0, 5'd2), 1'b1, ids[1], dk(1), 1'b0, 1'b1, dk(2));
    chk("wrap_setup_count", 64'(o_count), 64'd3);
    for (int k = 3; k < 23; k++) begin
      if (k == 13) begin
        for (int b = 0; b < 4; b++) begin
          idle(1'b0);
          chk("bp_vld", 64'(o_ret_vld), 64'd1);
          chk("bp_info", 64'(o_ret_info), 64'(sb[0].info));
          chk("bp_data", 64'(o_ret_data), 64'(sb[0].data));
        end
      end
      ids[k] = exp_tail[2:0];
      step(1'b1, mk(1'b1, 1'b0, 5'(k)), 1'b1, ids[k-1], dk(k-1), 1'b1, 1'b1, dk(k));
      chk("wrap_count", 64'(o_count), 64'd3);
    end
    step(1'b0, '0, 1'b1, ids[22], dk(22), 1'b1, 1'b0, 32'd0);
    idle(1'b1); idle(1'b1);
    chk("wrap_empty", 64'(o_empty), 64'd1);
    chk("wrap_sb", 64'(sb.size()), 64'd0);

    // Reset mid-flight
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(1'b1, 1'b0, 5'(i)), 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    chk("pre_reset_count", 64'(o_count), 64'd5);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    exp_tail = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 3'd2, 32'h5, 1'b0, 1'b0, 32'd0);
    chk("post_reset_err", 64'(o_resp_err), 64'd1);
    chk("post_reset_count", 64'(o_count), 64'd0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/tt_lq_return_buf.md
# tt_lq_return_buf

In-order load-return buffer for the vector/scalar memory path. Allocates load-queue IDs (`lqid`) at issue, stores the per-entry `lq_info_s`, and accepts out-of-order memory responses tagged with `mem_lqid`. Retires entries in allocation order to the register-file writeback stage. It is the response-side counterpart of the `mem_skidbuf_s` request path: the LSU sends requests carrying `mem_lqid`, and this block reassembles their returns.

## Interface
Parameters:
- `LQ_DEPTH`, default `tt_briscv_pkg::LQ_DEPTH` (8). Number of entries; must be a power of two, ≥2.
- `LQ_DEPTH_LOG2`, default `$clog2(LQ_DEPTH)`. Width of an ID.
- `DATA_W`, default 32. Load-return data width.

Ports:
- `i_clk` in 1: clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_alloc_vld` in 1: allocation request.
- `o_alloc_rdy` out 1: space available.
- `i_alloc_info` in `$bits(lq_info_s)`: entry metadata.
- `o_alloc_lqid` out `LQ_DEPTH_LOG2`: ID granted to the current allocation (the tail index).
- `i_resp_vld` in 1: memory response valid. There is no backpressure on this port.
- `i_resp_lqid` in `LQ_DEPTH_LOG2`: response tag.
- `i_resp_data` in `DATA_W`: response data.
- `o_ret_vld` out 1: head entry is complete.
- `i_ret_rdy` in 1: writeback accepts the head entry.
- `o_ret_info` out `$bits(lq_info_s)`: head metadata.
- `o_ret_data` out `DATA_W`: head data.
- `o_resp_err` out 1: illegal response seen on the previous cycle.
- `o_count` out `LQ_DEPTH_LOG2+1`: occupied entries.
- `o_empty` / `o_full` out 1: occupancy flags.

## Operation
- **Storage.** Each of the `LQ_DEPTH` entries holds: `valid`, `done`, `info`, `data`.
- **Pointers.** `head` and `tail` are each `LQ_DEPTH_LOG2+1` bits; the MSB is a wrap bit.
  - Empty: pointers are equal.
  - Full: index bits are equal and wrap bits differ.
- **Allocation.** Fires when `i_alloc_vld & o_alloc_rdy`. `o_alloc_rdy = !o_full`; it does not look ahead to a same-cycle retire.
  - The entry at `tail` gets `valid=1` and `info=i_alloc_info`.
  - If `info.load==0` or `info.vl_is_zero==1`, set `done=1` and `data=0` at allocation. Otherwise set `done=0`.
  - `tail` increments.
- **Response.** On `i_resp_vld`, the response is legal iff entry `i_resp_lqid` has `valid=1`, `done=0` and `info.load=1`.
  - Legal: set `done=1` and `data=i_resp_data`.
  - Illegal: entry state is unchanged and `o_resp_err` pulses for one cycle on the next cycle.
- **Retire.**
  - `o_ret_vld = entry[head].valid & entry[head].done`.
  - `o_ret_info` and `o_ret_data` are driven combinationally from the head entry.
  - On `o_ret_vld & i_ret_rdy`: clear the head entry's `valid` and `done`, and increment `head`.
  - While `o_ret_vld & !i_ret_rdy`, outputs hold stable.
- **Simultaneous events.**
  - Alloc and retire in the same cycle: legal when not full; `o_count` is unchanged.
  - A response to the head entry in the same cycle as a retire of that entry is impossible, because a retired head is already done; it is flagged illegal.
  - A response to the entry being allocated in the same cycle is illegal, because the entry is not yet valid.
  - Alloc, response and retire may all occur in one cycle to distinct entries.
- **Out-of-order completion.** Younger entries may complete first. They wait until all older entries retire.

## Timing
- All state is registered on the `i_clk` rising edge.
- Reset is asynchronous on `i_reset_n` low. While reset is asserted:
  - all `valid`/`done` bits are 0, and `head = tail = 0`;
  - `o_ret_vld=0`, `o_resp_err=0`, `o_count=0`, `o_empty=1`, `o_full=0`, `o_alloc_rdy=1`, `o_alloc_lqid=0`;
  - `o_ret_info` and `o_ret_data` are 0.
- Reset mid-operation discards all entries; any response arriving afterward is flagged illegal.
- **Latencies:**
  - Non-load allocation → `o_ret_vld` at the next cycle if the entry is the head.
  - Response to the head → `o_ret_vld` at the next cycle.
  - Retire handshake → the next entry is visible the following cycle. Back-to-back retire is one per cycle.
- `o_alloc_lqid` is valid in the same cycle as `i_alloc_vld`; it equals `tail[LQ_DEPTH_LOG2-1:0]`.
- `o_count`, `o_empty` and `o_full` are derived from the registered pointers.
- Pointers wrap modulo `2*LQ_DEPTH` with no skipped IDs.

## Test plan
- **Fill/drain.** Reset, then allocate 8 loads with IDs 0..7.
  - `o_full=1`, `o_alloc_rdy=0`.
  - Respond to all IDs in order and hold `i_ret_rdy=1`: 8 retires in order, one per cycle, then `o_empty=1`.
- **Out-of-order.** Allocate loads with IDs 0,1,2; respond 2, then 1, then 0 (data `0xC`, `0xB`, `0xA`).
  - `o_ret_vld` stays 0 until ID 0 returns.
  - Data then retires as `0xA`, `0xB`, `0xC` on consecutive cycles.
- **Non-load/vl0 bypass.** Allocate with `load=0`, then one with `vl_is_zero=1`.
  - Each retires one cycle after becoming the head, with data 0 and no response needed.
- **Illegal responses.** Three cases, each giving `o_resp_err=1` for one cycle with no state change:
  - a response to a free ID;
  - a duplicate response to an already-done ID;
  - a response to a `load=0` entry.
- **Wrap and simultaneous.** Run 20 alloc/retire pairs with 3 entries outstanding.
  - IDs cycle 0..7 and wrap.
  - Same-cycle alloc+retire keeps `o_count=3`.
  - Backpressure `i_ret_rdy=0` for 4 cycles holds the outputs stable.
- **Reset mid-flight.** Assert `i_reset_n=0` with 5 entries outstanding.
  - All outputs return to their reset values immediately.
  - A subsequent response to ID 2 gives `o_resp_err=1`.
